// File: rtl/event_blinker_pkg.sv
// Shared types and defaults for the event blinker slice.
// FSM encoding, default timing constants and width helpers.
package event_blinker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int DEF_F_COUNT     = 1000;
  localparam int DEF_ON_TICKS    = 20000;
  localparam int DEF_OFF_TICKS   = 10000;
  localparam int DEF_MAX_PENDING = 7;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/event_blinker_if.sv
// Event/LED bundle between the event source and the blinker.
// Overflow signals exist only when BLINK_OVF_EN is defined.
interface event_blinker_if
  import event_blinker_pkg::*;
#(
  parameter int MAX_PENDING = DEF_MAX_PENDING
) ();

  localparam int PW = $clog2(MAX_PENDING + 1);

  logic          i_event;
  logic          o_led;
  logic          o_busy;
  logic [PW-1:0] o_pending;
`ifdef BLINK_OVF_EN
  logic          o_ovf;
  logic          i_ovf_clr;

  modport master (
    output i_event, i_ovf_clr,
    input  o_led, o_busy, o_pending, o_ovf
  );
  modport slave (
    input  i_event, i_ovf_clr,
    output o_led, o_busy, o_pending, o_ovf
  );
`else
  modport master (
    output i_event,
    input  o_led, o_busy, o_pending
  );
  modport slave (
    input  i_event,
    output o_led, o_busy, o_pending
  );
`endif

endinterface

// File: rtl/event_blinker_tick_prescaler.sv
// Enable-tick timebase: counts 0..F_COUNT-1, one-clk tick on wrap.
// i_clr restarts the count so the next tick is a full period away.
module tick_prescaler
  import event_blinker_pkg::*;
#(
  parameter int F_COUNT = DEF_F_COUNT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int W = clog2_min1(F_COUNT);

  logic [W-1:0] cnt_q, cnt_d;

  assign o_tick = (cnt_q == W'(F_COUNT - 1));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (i_clr || o_tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/event_blinker.sv
// Turns single-cycle events into ON/GAP LED blinks with a pending queue.
// Define BLINK_OVF_EN to get the sticky o_ovf flag and i_ovf_clr.
module event_blinker
  import event_blinker_pkg::*;
#(
  parameter int F_COUNT     = DEF_F_COUNT,
  parameter int ON_TICKS    = DEF_ON_TICKS,
  parameter int OFF_TICKS   = DEF_OFF_TICKS,
  parameter int MAX_PENDING = DEF_MAX_PENDING
) (
  input  logic            clk,
  input  logic            rst,
  event_blinker_if.slave  bus
);

  localparam int TW = clog2_min1(max_i(ON_TICKS, OFF_TICKS));
  localparam int PW = $clog2(MAX_PENDING + 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          tick, clr;
  logic          on_end, gap_end;
  logic          direct, dec, inc, full;

  tick_prescaler #(
    .F_COUNT (F_COUNT)
  ) u_presc (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (clr),
    .o_tick (tick)
  );

  assign on_end  = tick && (tcnt_q == TW'(ON_TICKS - 1));
  assign gap_end = tick && (tcnt_q == TW'(OFF_TICKS - 1));
  assign clr     = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    direct  = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_event) begin
          state_d = ST_ON;
          direct  = 1'b1;
        end
      end
      ST_ON: begin
        if (on_end) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_end) begin
          if (pend_q != '0) begin
            state_d = ST_ON;
            dec     = 1'b1;
          end else if (bus.i_event) begin
            state_d = ST_ON;
            direct  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tick count restarts with the prescaler on every phase change
  always_comb begin
    tcnt_d = tcnt_q;
    if (tick && state_q != ST_IDLE)
      tcnt_d = tcnt_q + TW'(1);
    if (clr || state_q == ST_IDLE)
      tcnt_d = '0;
  end

  assign inc  = bus.i_event && !direct;
  assign full = (pend_q == PW'(MAX_PENDING));

  always_comb begin
    pend_d = pend_q;
    unique case ({inc, dec})
      2'b10:   if (!full) pend_d = pend_q + PW'(1);
      2'b01:   pend_d = pend_q - PW'(1);
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.o_led     = (state_q == ST_ON);
  assign bus.o_busy    = (state_q != ST_IDLE);
  assign bus.o_pending = pend_q;

`ifdef BLINK_OVF_EN
  logic drop;
  logic ovf_q, ovf_d;

  assign drop = inc && !dec && full;

  always_comb begin
    ovf_d = ovf_q;
    if (bus.i_ovf_clr) ovf_d = 1'b0;
    if (drop)          ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign bus.o_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_event_blinker.sv
// Scoreboard bench for event_blinker: cycle-count reference model
// feeds an expectation queue, a negedge monitor pops and compares.
module tb_event_blinker;
  import event_blinker_pkg::*;

  localparam int F    = 4;
  localparam int ONT  = 3;
  localparam int OFFT = 2;
  localparam int MAXP = 3;
  localparam int ON_CLK  = F * ONT;
  localparam int GAP_CLK = F * OFFT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  event_blinker_if #(.MAX_PENDING(MAXP)) bus ();

  event_blinker #(
    .F_COUNT     (F),
    .ON_TICKS    (ONT),
    .OFF_TICKS   (OFFT),
    .MAX_PENDING (MAXP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit led;
    bit busy;
    int pend;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference: mode 0=dark idle, 1=lit, 2=gap; left = clk left in phase
  int m_mode = 0;
  int m_left = 0;
  int m_pend = 0;
  bit m_ovf  = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, required %0d",
               nm, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_left = 0;
    m_pend = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge(input bit ev, input bit clr);
    bit drop;
    bit queue_ev;
    drop     = 1'b0;
    queue_ev = 1'b0;
    case (m_mode)
      0: begin
        if (ev) begin
          m_mode = 1;
          m_left = ON_CLK;
        end
      end
      1: begin
        queue_ev = ev;
        if (m_left == 1) begin
          m_mode = 2;
          m_left = GAP_CLK;
        end else begin
          m_left--;
        end
      end
      default: begin
        if (m_left == 1) begin
          if (m_pend > 0) begin
            m_mode = 1;
            m_left = ON_CLK;
            if (!ev) m_pend--;
          end else if (ev) begin
            m_mode = 1;
            m_left = ON_CLK;
          end else begin
            m_mode = 0;
          end
        end else begin
          m_left--;
          queue_ev = ev;
        end
      end
    endcase
    if (queue_ev) begin
      if (m_pend < MAXP) m_pend++;
      else drop = 1'b1;
    end
    if (drop)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.led  = (m_mode == 1);
    e.busy = (m_mode != 0);
    e.pend = m_pend;
    e.ovf  = m_ovf;
    return e;
  endfunction

  task automatic drive(input bit ev, input bit clr);
    bus.i_event = ev;
`ifdef BLINK_OVF_EN
    bus.i_ovf_clr = clr;
`endif
  endtask

  task automatic step(input bit ev, input bit clr);
    drive(ev, clr);
    @(posedge clk);
    model_edge(ev, clr);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic chk_dark(input string nm);
    chk({nm, "_led"},  int'(bus.o_led), 0);
    chk({nm, "_busy"}, int'(bus.o_busy), 0);
    chk({nm, "_pend"}, int'(bus.o_pending), 0);
`ifdef BLINK_OVF_EN
    chk({nm, "_ovf"},  int'(bus.o_ovf), 0);
`endif
  endtask

  // Asynchronous reset away from any clock edge
  task automatic do_reset();
    @(negedge clk);
    #1;
    drive(1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_dark("async_rst");
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      exp_q.push_back(model_out());
    end
    #1;
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("led",  int'(bus.o_led),     int'(e.led));
        chk("busy", int'(bus.o_busy),    int'(e.busy));
        chk("pend", int'(bus.o_pending), e.pend);
`ifdef BLINK_OVF_EN
        chk("ovf",  int'(bus.o_ovf),     int'(e.ovf));
`endif
      end
    end
  end

  initial begin : stim
    drive(1'b0, 1'b0);
    #1;
    chk_dark("por");
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      exp_q.push_back(model_out());
    end
    #1;
    rst = 1'b0;

    // single blink
    step(1'b1, 1'b0);
    idle(25);

    // two pulses 3 clk apart
    step(1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b0);
    idle(45);

    // five pulses during first ON, saturation, then clear
    step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    idle(85);
    step(1'b0, 1'b1);
    idle(3);

    // event on the final GAP clk: direct GAP->ON
    step(1'b1, 1'b0);
    idle(ON_CLK + GAP_CLK - 1);
    step(1'b1, 1'b0);
    idle(25);

    // reset 5 clk into ON with two pending
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    idle(2);
    do_reset();
    idle(30);

    // randomized traffic with sporadic resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) == 0,
             $urandom_range(0, 15) == 0);
      end
    end
    idle(40);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++)
      @(negedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
